// File: rtl/snake_input_ctrl_pkg.sv
// Shared definitions for the Snake input controller: heading codes, button
// indices and the turn-legality helper used by the pending-turn logic.
package snake_input_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_UP    = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  localparam int BTN_R = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_D = 3;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

  // A turn is only meaningful if it neither repeats nor reverses the reference heading.
  function automatic logic turnLegal(input logic [1:0] refDir, input logic [1:0] cand);
    return (cand != refDir) && (cand != opposite(refDir));
  endfunction

endpackage

// File: rtl/snake_input_ctrl_btn_debounce.sv
// One button channel: 2-FF synchronizer, stable-level debouncer and a
// registered rising-edge one-shot.
module snake_btn_debounce
  import snake_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stableDly_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle that agrees with the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      stableDly_q <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      pulse_q     <= stable_q & ~stableDly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake input side: four conditioned buttons, move-tick generator and committed heading.
// Define DIR_QUEUE_EN for a 2-entry turn FIFO instead of the single overwrite slot.
module snake_input_ctrl
  import snake_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MOVE_PERIOD     = 10_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       run,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  output logic [3:0] btn_pulse,
  output logic [1:0] dir,
  output logic       move_tick,
  output logic       turn_accepted
);

  localparam int TW = (MOVE_PERIOD > 2) ? $clog2(MOVE_PERIOD) : 1;

  logic [3:0]    btnRaw;
  logic [3:0]    btnPulse;
  logic          candValid;
  logic [1:0]    candDir;
  logic          terminal;
  logic [TW-1:0] tickCnt_q, tickCnt_d;
  logic [1:0]    dir_q, dir_d;
  logic          moveTick_q;
  logic          turnAcc_q;
  logic          commitValid;
  logic [1:0]    commitDir;

  assign btnRaw[BTN_R] = BtnR;
  assign btnRaw[BTN_U] = BtnU;
  assign btnRaw[BTN_L] = BtnL;
  assign btnRaw[BTN_D] = BtnD;

  for (genvar i = 0; i < 4; i++) begin : gBtn
    snake_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDeb (
      .Clk     (Clk),
      .Reset   (Reset),
      .btn_i   (btnRaw[i]),
      .pulse_o (btnPulse[i])
    );
  end

  always_comb begin
    candValid = |btnPulse;
    candDir   = DIR_RIGHT;
    if (btnPulse[BTN_U])      candDir = DIR_UP;
    else if (btnPulse[BTN_D]) candDir = DIR_DOWN;
    else if (btnPulse[BTN_L]) candDir = DIR_LEFT;
  end

  // Dropping run discards the partial period so the next tick is a full period away.
  always_comb begin
    terminal  = run && (tickCnt_q == TW'(MOVE_PERIOD - 1));
    tickCnt_d = '0;
    if (run && !terminal) tickCnt_d = tickCnt_q + TW'(1);
  end

`ifdef DIR_QUEUE_EN
  logic [1:0] fifoDir_q [2];
  logic [1:0] fifoDir0_d, fifoDir1_d;
  logic [1:0] fifoCnt_q, fifoCnt_d;
  logic [1:0] refDir;
  logic       push, pop;

  always_comb begin
    pop        = terminal && (fifoCnt_q != 2'd0);
    refDir     = (fifoCnt_q == 2'd0) ? dir_q :
                 (fifoCnt_q == 2'd2) ? fifoDir_q[1] : fifoDir_q[0];
    push       = candValid && (fifoCnt_q != 2'd2) && turnLegal(refDir, candDir);
    fifoDir0_d = fifoDir_q[0];
    fifoDir1_d = fifoDir_q[1];
    fifoCnt_d  = fifoCnt_q;
    if (pop) begin
      fifoDir0_d = fifoDir_q[1];
      fifoCnt_d  = fifoCnt_d - 2'd1;
    end
    if (push) begin
      if (fifoCnt_d == 2'd0) fifoDir0_d = candDir;
      else                   fifoDir1_d = candDir;
      fifoCnt_d = fifoCnt_d + 2'd1;
    end
    commitValid = pop;
    commitDir   = fifoDir_q[0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fifoDir_q[0] <= DIR_RIGHT;
      fifoDir_q[1] <= DIR_RIGHT;
      fifoCnt_q    <= 2'd0;
    end else begin
      fifoDir_q[0] <= fifoDir0_d;
      fifoDir_q[1] <= fifoDir1_d;
      fifoCnt_q    <= fifoCnt_d;
    end
  end
`else
  logic       pendValid_q, pendValid_d;
  logic [1:0] pendDir_q, pendDir_d;

  // A pulse arriving on the commit edge survives into the slot for the next tick.
  always_comb begin
    commitValid = terminal && pendValid_q && turnLegal(dir_q, pendDir_q);
    commitDir   = pendDir_q;
    pendValid_d = terminal ? 1'b0 : pendValid_q;
    pendDir_d   = pendDir_q;
    if (candValid) begin
      pendValid_d = 1'b1;
      pendDir_d   = candDir;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pendValid_q <= 1'b0;
      pendDir_q   <= DIR_RIGHT;
    end else begin
      pendValid_q <= pendValid_d;
      pendDir_q   <= pendDir_d;
    end
  end
`endif

  assign dir_d = commitValid ? commitDir : dir_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tickCnt_q  <= '0;
      dir_q      <= DIR_RIGHT;
      moveTick_q <= 1'b0;
      turnAcc_q  <= 1'b0;
    end else begin
      tickCnt_q  <= tickCnt_d;
      dir_q      <= dir_d;
      moveTick_q <= terminal;
      turnAcc_q  <= commitValid;
    end
  end

  assign btn_pulse     = btnPulse;
  assign dir           = dir_q;
  assign move_tick     = moveTick_q;
  assign turn_accepted = turnAcc_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed and randomized checks of snake_input_ctrl (default single-slot build)
// against a behavioural model built from press durations and run-time counts.
module tb_snake_input_ctrl;

  localparam int DEB = 4;
  localparam int PER = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       run = 1'b0;
  logic       BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
  logic [3:0] btn_pulse;
  logic [1:0] dir;
  logic       move_tick;
  logic       turn_accepted;

  int vectors = 0;
  int miscompares = 0;

  int         edgeNo;
  int         highLen [4];
  int         pulseEdge [4];
  int         runLen;
  logic [3:0] expPulse;
  logic [1:0] expDir;
  logic       expTick;
  logic       expAcc;
  logic       pendValidM;
  logic [1:0] pendDirM;

  always #5 Clk = ~Clk;

  snake_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .MOVE_PERIOD(PER)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .run           (run),
    .BtnU          (BtnU),
    .BtnD          (BtnD),
    .BtnL          (BtnL),
    .BtnR          (BtnR),
    .btn_pulse     (btn_pulse),
    .dir           (dir),
    .move_tick     (move_tick),
    .turn_accepted (turn_accepted)
  );

  // Same-cycle presses resolve Up, then Down, then Left, then Right.
  function automatic logic [1:0] candidateOf(input logic [3:0] p);
    if (p[1]) return 2'b01;
    if (p[3]) return 2'b11;
    if (p[2]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic modelReset();
    edgeNo     = 0;
    runLen     = 0;
    expPulse   = 4'b0000;
    expDir     = 2'b00;
    expTick    = 1'b0;
    expAcc     = 1'b0;
    pendValidM = 1'b0;
    pendDirM   = 2'b00;
    for (int b = 0; b < 4; b++) begin
      highLen[b]   = 0;
      pulseEdge[b] = -1;
    end
  endtask

  // A press held for at least DEB samples yields one pulse DEB+2 edges after its first sample.
  task automatic modelEdge();
    logic [3:0] raw;
    raw    = {BtnD, BtnL, BtnU, BtnR};
    edgeNo = edgeNo + 1;
    runLen = run ? runLen + 1 : 0;
    expTick = run && (runLen % PER == 0);
    expAcc  = 1'b0;
    if (expTick) begin
      if (pendValidM && pendDirM != expDir && pendDirM != (expDir ^ 2'b10)) begin
        expDir = pendDirM;
        expAcc = 1'b1;
      end
      pendValidM = 1'b0;
    end
    if (expPulse != 4'b0000) begin
      pendValidM = 1'b1;
      pendDirM   = candidateOf(expPulse);
    end
    for (int b = 0; b < 4; b++) begin
      highLen[b] = raw[b] ? highLen[b] + 1 : 0;
      if (highLen[b] == DEB) pulseEdge[b] = edgeNo + 3;
      expPulse[b] = (pulseEdge[b] == edgeNo);
    end
  endtask

  task automatic checkOutput();
    vectors++;
    assert (btn_pulse === expPulse) else begin
      miscompares++;
      $error("[TB] FAIL btn_pulse observed=%b expected=%b edge=%0d", btn_pulse, expPulse, edgeNo);
    end
    vectors++;
    assert (dir === expDir) else begin
      miscompares++;
      $error("[TB] FAIL dir observed=%b expected=%b edge=%0d", dir, expDir, edgeNo);
    end
    vectors++;
    assert (move_tick === expTick) else begin
      miscompares++;
      $error("[TB] FAIL move_tick observed=%b expected=%b edge=%0d", move_tick, expTick, edgeNo);
    end
    vectors++;
    assert (turn_accepted === expAcc) else begin
      miscompares++;
      $error("[TB] FAIL turn_accepted observed=%b expected=%b edge=%0d", turn_accepted, expAcc, edgeNo);
    end
  endtask

  task automatic applyStimulus(input logic u, input logic d, input logic l, input logic r,
                               input logic rn);
    @(negedge Clk);
    BtnU = u; BtnD = d; BtnL = l; BtnR = r; run = rn;
    @(posedge Clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  // Reset is raised between edges so the outputs must clear without a clock.
  task automatic applyReset();
    @(negedge Clk);
    Reset = 1'b1;
    BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0; run = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge Clk);
    #1;
    checkOutput();
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic rn);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rn);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r,
                       input int n, input logic rn);
    for (int i = 0; i < n; i++) applyStimulus(u, d, l, r, rn);
  endtask

  initial begin
    logic       rn;
    logic       lvl [4];
    logic       segHigh [4];
    int         segLeft [4];

    modelReset();
    applyReset();
    idle(3, 1'b0);

    $display("[TB] button conditioning: hold and glitch");
    press(1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    idle(12, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    idle(12, 1'b0);

    $display("[TB] move tick gating");
    idle(24, 1'b1);
    idle(20, 1'b0);
    idle(16, 1'b1);

    $display("[TB] turn up, then reversal to down");
    press(1'b1, 1'b0, 1'b0, 1'b0, 6, 1'b1);
    idle(20, 1'b1);
    press(1'b0, 1'b1, 1'b0, 1'b0, 6, 1'b1);
    idle(20, 1'b1);

    $display("[TB] reset while heading up and mid-period");
    applyReset();
    idle(5, 1'b1);
    applyReset();
    idle(10, 1'b1);

    $display("[TB] simultaneous up+left, then right while right");
    press(1'b1, 1'b0, 1'b1, 1'b0, 6, 1'b1);
    idle(20, 1'b1);
    applyReset();
    press(1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b1);
    idle(20, 1'b1);

    $display("[TB] up then left within one period");
    applyReset();
    press(1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    press(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0);
    idle(4, 1'b0);
    idle(12, 1'b1);

    $display("[TB] randomized presses and run toggling");
    rn = 1'b1;
    for (int b = 0; b < 4; b++) begin
      segHigh[b] = 1'b0;
      segLeft[b] = int'($urandom_range(DEB + 2, DEB + 10));
    end
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (segLeft[b] == 0) begin
          if (segHigh[b]) begin
            segHigh[b] = 1'b0;
            segLeft[b] = int'($urandom_range(DEB + 2, DEB + 10));
          end else begin
            segHigh[b] = 1'b1;
            if ($urandom_range(0, 1) == 0) segLeft[b] = int'($urandom_range(1, DEB - 1));
            else                           segLeft[b] = int'($urandom_range(DEB, DEB + 8));
          end
        end
        lvl[b]     = segHigh[b];
        segLeft[b] = segLeft[b] - 1;
      end
      if ($urandom_range(0, 99) < 3) rn = ~rn;
      applyStimulus(lvl[1], lvl[3], lvl[2], lvl[0], rn);
    end
    idle(DEB + 6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
